sram_access_scheduler: RTL

Single-clock sequencer that shares one asynchronous SRAM chip between the CPU instruction port and the data port. Accepts held-request/ack-pulse transactions from both requesters, arbitrates, and drives the chip strobes with configurable wait states. Sits between the bus slaves and the board SRAM pins; the top level joins sram_dq_o/sram_dq_oe into the tristate pad.

---
 rtl/sram_access_scheduler_pkg.sv | 22 ++
 rtl/sram_sched_arbiter.sv | 36 +++
 rtl/sram_access_scheduler.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sram_access_scheduler_pkg.sv
// Shared types for the SRAM access scheduler.
//   SramChipAddress_t : 20-bit SRAM word address
//   SramSchedState_t  : sequencer state encoding
//   Grant_t           : which requester owns the current transaction
package sram_access_scheduler_pkg;

  typedef logic [19:0] SramChipAddress_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_STROBE,
    WR_SETUP,
    WR_STROBE,
    DONE
  } SramSchedState_t;

  typedef enum logic {
    INST,
    DATA
  } Grant_t;

endpackage

// File: rtl/sram_sched_arbiter.sv
// Combinational grant between the instruction and data requesters.
// Ports:
//   inst_req, data_req : held requests
//   last_grant         : previous owner (only when SRAM_SCHED_ROUND_ROBIN_EN is defined)
//   grant_valid        : at least one request present
//   grant              : selected requester
// Macro SRAM_SCHED_ROUND_ROBIN_EN: conflicts alternate owner; otherwise data
// always wins a conflict.
module sram_sched_arbiter
  import sram_access_scheduler_pkg::*;
(
  input  logic   inst_req,
  input  logic   data_req,
`ifdef SRAM_SCHED_ROUND_ROBIN_EN
  input  Grant_t last_grant,
`endif
  output logic   grant_valid,
  output Grant_t grant
);

  always_comb begin
    grant_valid = inst_req | data_req;
    grant       = DATA;
    if (inst_req && data_req) begin
`ifdef SRAM_SCHED_ROUND_ROBIN_EN
      if (last_grant == DATA) grant = INST;
      else                    grant = DATA;
`else
      grant = DATA;
`endif
    end else if (inst_req) begin
      grant = INST;
    end
  end

endmodule

// File: rtl/sram_access_scheduler.sv
// Shares one asynchronous SRAM between the instruction and data ports.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   inst_req/addr/rdata/ack       : instruction read port (held req, ack pulse)
//   data_req/we/addr/wdata/be     : data port request, data_rdata/ack response
//   busy                          : sequencer not in IDLE
//   sram_addr/ce_n/oe_n/we_n/be_n : registered chip strobes
//   sram_dq_o/dq_oe, sram_dq_i    : data bus halves, joined into a pad above
// Parameter WAIT_CYCLES (1..15): strobe-active cycles per access.
// Macro SRAM_SCHED_ROUND_ROBIN_EN: alternate priority on conflicts.
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | waiting; grants and latches a request
// RD_STROBE | ce/oe asserted for WAIT_CYCLES, capture on last
// WR_SETUP  | ce asserted, data driven, we_n still high
// WR_STROBE | we_n low for WAIT_CYCLES
// DONE      | ack pulse, strobes released, write data held
module sram_access_scheduler
  import sram_access_scheduler_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_req,
  input  SramChipAddress_t inst_addr,
  output logic [31:0]      inst_rdata,
  output logic             inst_ack,
  input  logic             data_req,
  input  logic             data_we,
  input  SramChipAddress_t data_addr,
  input  logic [31:0]      data_wdata,
  input  logic [3:0]       data_be,
  output logic [31:0]      data_rdata,
  output logic             data_ack,
  output logic             busy,
  output SramChipAddress_t sram_addr,
  output logic             sram_ce_n,
  output logic             sram_oe_n,
  output logic             sram_we_n,
  output logic [3:0]       sram_be_n,
  output logic [31:0]      sram_dq_o,
  output logic             sram_dq_oe,
  input  logic [31:0]      sram_dq_i
);

  localparam int unsigned      CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  SramSchedState_t  state;
  logic [CNT_W-1:0] cnt;
  Grant_t           cur_grant;
  logic             arb_valid;
  Grant_t           arb_grant;

`ifdef SRAM_SCHED_ROUND_ROBIN_EN
  Grant_t           last_grant;
`endif

  sram_sched_arbiter u_arb (
    .inst_req    (inst_req),
    .data_req    (data_req),
`ifdef SRAM_SCHED_ROUND_ROBIN_EN
    .last_grant  (last_grant),
`endif
    .grant_valid (arb_valid),
    .grant       (arb_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cur_grant  <= INST;
`ifdef SRAM_SCHED_ROUND_ROBIN_EN
      last_grant <= DATA;
`endif
      inst_rdata <= '0;
      inst_ack   <= 1'b0;
      data_rdata <= '0;
      data_ack   <= 1'b0;
      busy       <= 1'b0;
      sram_addr  <= '0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= 4'hF;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            cur_grant <= arb_grant;
`ifdef SRAM_SCHED_ROUND_ROBIN_EN
            last_grant <= arb_grant;
`endif
            busy      <= 1'b1;
            sram_ce_n <= 1'b0;
            if (arb_grant == DATA && data_we) begin
              sram_addr  <= data_addr;
              sram_be_n  <= ~data_be;
              sram_dq_o  <= data_wdata;
              sram_dq_oe <= 1'b1;
              state      <= WR_SETUP;
            end else begin
              sram_addr <= (arb_grant == DATA) ? data_addr : inst_addr;
              sram_oe_n <= 1'b0;
              sram_be_n <= 4'h0;
              cnt       <= CNT_LOAD;
              state     <= RD_STROBE;
            end
          end
        end
        RD_STROBE: begin
          if (cnt == '0) begin
            // Capture on the edge that closes the last strobe cycle.
            if (cur_grant == INST) begin
              inst_rdata <= sram_dq_i;
              inst_ack   <= 1'b1;
            end else begin
              data_rdata <= sram_dq_i;
              data_ack   <= 1'b1;
            end
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_be_n <= 4'hF;
            state     <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WR_SETUP: begin
          sram_we_n <= 1'b0;
          cnt       <= CNT_LOAD;
          state     <= WR_STROBE;
        end
        WR_STROBE: begin
          if (cnt == '0) begin
            // Only the data port writes; dq_oe stays up through DONE as hold.
            data_ack  <= 1'b1;
            sram_we_n <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_be_n <= 4'hF;
            state     <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          inst_ack   <= 1'b0;
          data_ack   <= 1'b0;
          sram_dq_oe <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
